// File: rtl/mod107_pkg.sv
// Shared constants and state encoding for the mod-107 residue datapath.
`default_nettype none

package mod107_pkg;

  localparam int MOD    = 107;
  localparam int RW     = 7;
  localparam int CHUNKS = 17;
  localparam int CW     = $clog2(CHUNKS);

  localparam logic [CW-1:0] LAST_IDX = CW'(CHUNKS - 1);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mod107_add.sv
// Combinational modular add: (acc + in_res) fully reduced mod 107, plus an out-of-range flag on in_res.
`default_nettype none

module mod107_add
  import mod107_pkg::*;
(
  input  logic [RW-1:0] acc,
  input  logic [RW-1:0] in_res,
  output logic [RW-1:0] sum_red,
  output logic          out_of_range
);

  localparam logic [RW:0]   ONE_MOD_W = (RW + 1)'(MOD);
  localparam logic [RW:0]   TWO_MOD_W = (RW + 1)'(2 * MOD);
  localparam logic [RW-1:0] ONE_MOD_N = RW'(MOD);
  localparam logic [RW-1:0] TWO_MOD_N = RW'(2 * MOD);

  logic [RW:0] sum;

  // Every reduced result is below 128, so subtracting in RW bits modulo 2^RW
  // yields the exact value even though 2*MOD itself does not fit in RW bits.
  always_comb begin
    sum = {1'b0, acc} + {1'b0, in_res};
    if (sum >= TWO_MOD_W) begin
      sum_red = sum[RW-1:0] - TWO_MOD_N;
    end else if (sum >= ONE_MOD_W) begin
      sum_red = sum[RW-1:0] - ONE_MOD_N;
    end else begin
      sum_red = sum[RW-1:0];
    end
    out_of_range = (in_res >= ONE_MOD_N);
  end

endmodule

`default_nettype wire

// File: rtl/mod107_residue_acc.sv
// Accumulates 17 per-chunk residues mod 107 over valid/ready and presents the operand residue.
`default_nettype none

module mod107_residue_acc
  import mod107_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_res,
  output logic [CW-1:0] chunk_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_res,
  output logic          range_err
);

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] acc;
  logic [RW-1:0] sum_red;
  logic          res_oor;
  logic          beat;
  logic          last_beat;
  logic          result_taken;

  mod107_add u_add (
    .acc          (acc),
    .in_res       (in_res),
    .sum_red      (sum_red),
    .out_of_range (res_oor)
  );

  // Handshake signals depend on state only, so in_ready never sees out_ready or in_valid.
  always_comb begin
    in_ready     = (state == ACC);
    out_valid    = (state == DONE);
    beat         = in_valid & in_ready;
    last_beat    = beat & (chunk_idx == LAST_IDX);
    result_taken = out_valid & out_ready;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACC;
    end else begin
      case (state)
        ACC:     if (last_beat)    state_nxt = DONE;
        DONE:    if (result_taken) state_nxt = ACC;
        default: state_nxt = ACC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      chunk_idx <= '0;
      out_res   <= '0;
      range_err <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      chunk_idx <= '0;
      range_err <= 1'b0;
    end else if (beat) begin
      acc       <= sum_red;
      range_err <= range_err | res_oor;
      if (last_beat) begin
        chunk_idx <= '0;
        out_res   <= sum_red;
      end else begin
        chunk_idx <= chunk_idx + 1'b1;
      end
    end else if (result_taken) begin
      acc       <= '0;
      range_err <= 1'b0;
    end
  end

endmodule

`default_nettype wire
